// File: rtl/sram_controller_param.sv
// Avalon-MM slave to asynchronous SRAM bridge with programmable wait states,
// a write hold cycle and a read-to-write bus turnaround.
module sram_controller_param #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1,
    parameter int TURNAROUND = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    inout  wire  [DATA_W-1:0]   SRAM_DQ,
    output logic [ADDR_W-1:0]   SRAM_ADDR,
    output logic [DATA_W/8-1:0] SRAM_BE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] RD_LOAD   = 4'(READ_WAIT);
    localparam logic [3:0] WR_LOAD   = 4'(WRITE_WAIT);
    localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    typedef enum logic [2:0] {IDLE, READ, WRITE, WHOLD, TURN} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [BE_W-1:0]     be_n_nxt;
    logic                ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic                dq_oe, dq_oe_nxt;
    logic [DATA_W-1:0]   dq_out, dq_out_nxt;
    logic [DATA_W-1:0]   capture, capture_nxt;
    logic                rd_pend, rd_pend_nxt;

    assign waitrequest = reset | (state != IDLE);
    assign SRAM_DQ     = dq_oe ? dq_out : {DATA_W{1'bz}};

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_nxt    = SRAM_ADDR;
        be_n_nxt    = SRAM_BE_N;
        ce_n_nxt    = SRAM_CE_N;
        oe_n_nxt    = SRAM_OE_N;
        we_n_nxt    = SRAM_WE_N;
        dq_oe_nxt   = dq_oe;
        dq_out_nxt  = dq_out;
        capture_nxt = capture;
        rd_pend_nxt = 1'b0;
        case (state)
            IDLE: begin
                // write takes priority when both requests are raised together
                if (write) begin
                    state_nxt  = WRITE;
                    addr_nxt   = address;
                    dq_out_nxt = writedata;
                    be_n_nxt   = ~byteenable;
                    ce_n_nxt   = 1'b0;
                    we_n_nxt   = 1'b0;
                    oe_n_nxt   = 1'b1;
                    dq_oe_nxt  = 1'b1;
                    cnt_nxt    = WR_LOAD;
                end else if (read) begin
                    state_nxt = READ;
                    addr_nxt  = address;
                    be_n_nxt  = '0;
                    ce_n_nxt  = 1'b0;
                    oe_n_nxt  = 1'b0;
                    cnt_nxt   = RD_LOAD;
                end
            end
            READ: begin
                if (cnt == 4'd0) begin
                    capture_nxt = SRAM_DQ;
                    rd_pend_nxt = 1'b1;
                    ce_n_nxt    = 1'b1;
                    oe_n_nxt    = 1'b1;
                    be_n_nxt    = '1;
                    cnt_nxt     = TURN_LOAD;
                    state_nxt   = (TURNAROUND > 0) ? TURN : IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WRITE: begin
                if (cnt == 4'd0) begin
                    state_nxt = WHOLD;
                    we_n_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WHOLD: begin
                state_nxt = IDLE;
                ce_n_nxt  = 1'b1;
                dq_oe_nxt = 1'b0;
                be_n_nxt  = '1;
            end
            TURN: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            SRAM_ADDR     <= '0;
            SRAM_BE_N     <= '1;
            SRAM_CE_N     <= 1'b1;
            SRAM_OE_N     <= 1'b1;
            SRAM_WE_N     <= 1'b1;
            dq_oe         <= 1'b0;
            dq_out        <= '0;
            capture       <= '0;
            rd_pend       <= 1'b0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            SRAM_ADDR     <= addr_nxt;
            SRAM_BE_N     <= be_n_nxt;
            SRAM_CE_N     <= ce_n_nxt;
            SRAM_OE_N     <= oe_n_nxt;
            SRAM_WE_N     <= we_n_nxt;
            dq_oe         <= dq_oe_nxt;
            dq_out        <= dq_out_nxt;
            capture       <= capture_nxt;
            rd_pend       <= rd_pend_nxt;
            readdatavalid <= rd_pend;
            if (rd_pend) readdata <= capture;
        end
    end

endmodule

// File: tb/tb_sram_controller_param.sv
// Directed bench for sram_controller_param: default 16-bit instance with an
// SRAM model and scoreboard, plus a 32-bit zero-read-wait instance for reset.
module tb_sram_controller_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] address = '0;
    logic [1:0]  byteenable = '0;
    logic        read = 1'b0, write = 1'b0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        readdatavalid, waitrequest;
    wire  [15:0] sram_dq;
    logic [19:0] sram_addr;
    logic [1:0]  sram_be_n;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    logic        rst2 = 1'b1;
    logic [19:0] address2 = '0;
    logic [3:0]  be2 = '0;
    logic        read2 = 1'b0, write2 = 1'b0;
    logic [31:0] wd2 = '0;
    logic [31:0] rd2;
    logic        rdv2, wr2;
    wire  [31:0] dq2;
    logic [19:0] addr2;
    logic [3:0]  be_n2;
    logic        ce2, oe2, we2;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    logic [15:0] mem [0:1023];

    always #5 clk = ~clk;

    sram_controller_param dut (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest), .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr), .SRAM_BE_N(sram_be_n), .SRAM_CE_N(sram_ce_n),
        .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n)
    );

    sram_controller_param #(.DATA_W(32), .ADDR_W(20), .READ_WAIT(0),
                            .WRITE_WAIT(1), .TURNAROUND(1)) dut32 (
        .clk(clk), .reset(rst2), .address(address2), .byteenable(be2),
        .read(read2), .write(write2), .writedata(wd2), .readdata(rd2),
        .readdatavalid(rdv2), .waitrequest(wr2), .SRAM_DQ(dq2),
        .SRAM_ADDR(addr2), .SRAM_BE_N(be_n2), .SRAM_CE_N(ce2),
        .SRAM_OE_N(oe2), .SRAM_WE_N(we2)
    );

    // SRAM model: drives DQ while selected for read, stores enabled bytes while WE_N is low
    logic model_drive;
    assign model_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_dq = model_drive ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[0]) mem[sram_addr[9:0]][7:0]  = sram_dq[7:0];
            if (!sram_be_n[1]) mem[sram_addr[9:0]][15:8] = sram_dq[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (readdatavalid) begin
            if (sb.size() == 0) chk("rdv_unexpected", 32'(sb.size()), 32'd1);
            else chk("readdata", {16'h0, readdata}, {16'h0, sb.pop_front()});
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (waitrequest && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("wait_ready_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_read(input logic [19:0] a, input logic [15:0] exp);
        int oe_low = 0;
        int lat = 0;
        wait_ready();
        address = a; read = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        read = 1'b0;
        chk("rd_be_n", {30'h0, sram_be_n}, 32'h0);
        if (!sram_oe_n) oe_low++;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (!sram_oe_n) oe_low++;
            if (readdatavalid) begin
                lat = k;
                break;
            end
        end
        chk("rd_oe_low_cycles", 32'(oe_low), 32'd2);
        chk("rd_latency", 32'(lat), 32'd3);
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                            input logic [1:0] be, input logic [1:0] exp_be_n);
        int we_low = 0;
        int whold = 0;
        int busy = 0;
        wait_ready();
        address = a; writedata = d; byteenable = be; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        chk("wr_be_n", {30'h0, sram_be_n}, {30'h0, exp_be_n});
        chk("wr_dq", {16'h0, sram_dq}, {16'h0, d});
        if (!sram_we_n) we_low++;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (!sram_we_n) we_low++;
            if (!sram_ce_n && sram_we_n) begin
                whold++;
                chk("whold_dq", {16'h0, sram_dq}, {16'h0, d});
            end
            if (!waitrequest) begin
                busy = k;
                break;
            end
        end
        chk("wr_we_low_cycles", 32'(we_low), 32'd2);
        chk("wr_whold_cycles", 32'(whold), 32'd1);
        chk("wr_busy_cycles", 32'(busy), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit reached");
    end

    initial begin
        int rdv_cnt;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h012] = 16'hBEEF;
        mem[10'h050] = 16'hFFFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitrequest", {31'h0, waitrequest}, 32'd1);
        chk("rst_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        chk("rst_be_n", {30'h0, sram_be_n}, 32'h3);
        chk("rst_addr", {12'h0, sram_addr}, 32'h0);
        chk("rst_readdata", {16'h0, readdata}, 32'h0);
        chk("rst_rdv", {31'h0, readdatavalid}, 32'h0);
        chk("rst_dq_z", {31'h0, (sram_dq === 16'hzzzz)}, 32'd1);
        @(negedge clk);
        reset = 1'b0; rst2 = 1'b0;
        #1;
        chk("post_rst_waitrequest", {31'h0, waitrequest}, 32'd0);

        do_read(20'h00012, 16'hBEEF);
        do_write(20'h00100, 16'hA5C3, 2'b11, 2'b00);
        do_read(20'h00100, 16'hA5C3);
        do_write(20'h00050, 16'h1234, 2'b01, 2'b10);
        do_read(20'h00050, 16'hFF34);
        do_write(20'h00060, 16'h9999, 2'b00, 2'b11);
        do_read(20'h00060, 16'h0000);

        // read immediately followed by a pending write: one turnaround cycle
        wait_ready();
        address = 20'h00012; read = 1'b1;
        sb.push_back(16'hBEEF);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b1; address = 20'h00300;
        writedata = 16'h7777; byteenable = 2'b11;
        @(posedge clk); #1;
        chk("turn_wait_read", {31'h0, waitrequest}, 32'd1);
        @(posedge clk); #1;
        chk("turn_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        chk("turn_dq_z", {31'h0, (sram_dq === 16'hzzzz)}, 32'd1);
        chk("turn_waitrequest", {31'h0, waitrequest}, 32'd1);
        @(posedge clk); #1;
        chk("turn_done_idle", {31'h0, waitrequest}, 32'd0);
        @(posedge clk); #1;
        write = 1'b0;
        chk("turn_write_we", {31'h0, sram_we_n}, 32'd0);
        do_read(20'h00300, 16'h7777);

        // read and write together: write wins, no read data returned
        wait_ready();
        address = 20'h00200; writedata = 16'h5A5A; byteenable = 2'b11;
        read = 1'b1; write = 1'b1;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        chk("both_we", {31'h0, sram_we_n}, 32'd0);
        chk("both_oe", {31'h0, sram_oe_n}, 32'd1);
        rdv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (readdatavalid) rdv_cnt++;
        end
        chk("both_no_rdv", 32'(rdv_cnt), 32'd0);
        do_read(20'h00200, 16'h5A5A);

        // 32-bit instance: reset in the middle of a write
        @(negedge clk);
        address2 = 20'h00004; wd2 = 32'hDEADBEEF; be2 = 4'hF; write2 = 1'b1;
        @(posedge clk); #1;
        write2 = 1'b0;
        chk("w32_we", {31'h0, we2}, 32'd0);
        chk("w32_dq", dq2, 32'hDEADBEEF);
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        chk("w32_wait_in_reset", {31'h0, wr2}, 32'd1);
        @(posedge clk); #1;
        chk("w32_rst_strobes", {29'h0, ce2, oe2, we2}, 32'h7);
        chk("w32_rst_dq_z", {31'h0, (dq2 === 32'hzzzzzzzz)}, 32'd1);
        chk("w32_rst_be_n", {28'h0, be_n2}, 32'hF);
        chk("w32_rst_wait", {31'h0, wr2}, 32'd1);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("w32_wait_after_rst", {31'h0, wr2}, 32'd0);

        // 32-bit instance: reset between data capture and readdatavalid
        @(negedge clk);
        read2 = 1'b1; address2 = 20'h00008;
        @(posedge clk); #1;
        read2 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk("r32_rdv_suppressed", {31'h0, rdv2}, 32'd0);
        chk("r32_readdata_rst", rd2, 32'h0);
        @(negedge clk);
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("r32_rdv_after", {31'h0, rdv2}, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
